// File: rtl/seg_display_scanner_if.sv
// rtl/seg_display_scanner_if.sv - display scanner bus: parallel digit codes in, scanned segment/anode bus out
// Optional SEG_DISPLAY_SCANNER_BLINK_EN adds blink_mask.
interface seg_display_scanner_if #(
    parameter int DIGITS = 6
);
    logic              enable;
    logic [6:0]        disp0;
    logic [6:0]        disp1;
    logic [6:0]        disp2;
    logic [6:0]        disp3;
    logic [6:0]        disp4;
    logic [6:0]        disp5;
    logic [5:0]        dp_mask;
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
    logic [DIGITS-1:0] blink_mask;
`endif
    logic [6:0]        seg;
    logic              dp;
    logic [DIGITS-1:0] an;
    logic [2:0]        digit_idx;
    logic              frame_tick;

    modport master (
        output enable, disp0, disp1, disp2, disp3, disp4, disp5, dp_mask,
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
        output blink_mask,
`endif
        input  seg, dp, an, digit_idx, frame_tick
    );

    modport slave (
        input  enable, disp0, disp1, disp2, disp3, disp4, disp5, dp_mask,
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
        input  blink_mask,
`endif
        output seg, dp, an, digit_idx, frame_tick
    );
endinterface

// File: rtl/seg_display_scanner.sv
// rtl/seg_display_scanner.sv - time-multiplexed 7-segment scanner with per-slot dead time and per-frame snapshot
// Optional blink feature under SEG_DISPLAY_SCANNER_BLINK_EN.
module seg_display_scanner #(
    parameter int DIGITS         = 6,
    parameter int SCAN_DIV       = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
    ,
    parameter int BLINK_FRAMES   = 64
`endif
) (
    input  logic clk,
    input  logic reset,
    seg_display_scanner_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    localparam int                CW      = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]     LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]     BLANK_N = CW'(BLANK_CYCLES);
    localparam logic [6:0]        SEG_OFF = {7{SEG_ACTIVE_LOW != 0}};
    localparam logic              DP_OFF  = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{AN_ACTIVE_LOW != 0}};
    localparam logic [2:0]        IDX_MAX = 3'(DIGITS - 1);

    state_t            state, state_n, slot_start;
    logic [CW-1:0]     slot_cnt, slot_n;
    logic [2:0]        idx, idx_n;
    logic              capture, tick_n;
    logic [6:0]        snap_seg [DIGITS];
    logic [DIGITS-1:0] snap_dp;
    logic [6:0]        disp_sel [DIGITS];
    logic [DIGITS-1:0] dpm_sel;
    logic [6:0]        seg_q, seg_n;
    logic              dp_q, dp_n, tick_q;
    logic [DIGITS-1:0] an_q, an_n;
    logic              shown;

`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
    localparam int BW = $clog2(BLINK_FRAMES + 1);
    logic [DIGITS-1:0] snap_blink;
    logic [BW-1:0]     blink_cnt;
    logic              blink_phase;
`endif

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            disp_sel[i] = SEG_OFF;
            dpm_sel[i]  = 1'b0;
            case (i)
                0: begin disp_sel[i] = bus.disp0; dpm_sel[i] = bus.dp_mask[0]; end
                1: begin disp_sel[i] = bus.disp1; dpm_sel[i] = bus.dp_mask[1]; end
                2: begin disp_sel[i] = bus.disp2; dpm_sel[i] = bus.dp_mask[2]; end
                3: begin disp_sel[i] = bus.disp3; dpm_sel[i] = bus.dp_mask[3]; end
                4: begin disp_sel[i] = bus.disp4; dpm_sel[i] = bus.dp_mask[4]; end
                5: begin disp_sel[i] = bus.disp5; dpm_sel[i] = bus.dp_mask[5]; end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n    = state;
        slot_n     = slot_cnt;
        idx_n      = idx;
        capture    = 1'b0;
        tick_n     = 1'b0;
        slot_start = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
        if (!bus.enable) begin
            state_n = IDLE;
            slot_n  = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = slot_start;
                    slot_n  = '0;
                    idx_n   = '0;
                    capture = 1'b1;
                end
                BLANK, DRIVE: begin
                    if (slot_cnt >= LAST) begin
                        slot_n  = '0;
                        state_n = slot_start;
                        // Out-of-range indices (upsets) fall into the wrap path.
                        if (idx >= IDX_MAX) begin
                            idx_n   = '0;
                            capture = 1'b1;
                            tick_n  = 1'b1;
                        end else begin
                            idx_n = idx + 3'd1;
                        end
                    end else begin
                        slot_n  = slot_cnt + 1'b1;
                        state_n = (slot_n >= BLANK_N) ? DRIVE : BLANK;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Pins follow the current state, so they trail the counters by one edge.
    always_comb begin
        seg_n = SEG_OFF;
        dp_n  = DP_OFF;
        an_n  = AN_OFF;
        shown = 1'b1;
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
        shown = blink_phase;
`endif
        if (bus.enable && state == DRIVE) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == 3'(i)) begin
                    an_n[i] = ~AN_OFF[i];
`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
                    shown = blink_phase || !snap_blink[i];
`endif
                    if (shown) begin
                        seg_n = snap_seg[i];
                        dp_n  = snap_dp[i] ? ~DP_OFF : DP_OFF;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            slot_cnt <= '0;
            idx      <= '0;
            seg_q    <= SEG_OFF;
            dp_q     <= DP_OFF;
            an_q     <= AN_OFF;
            tick_q   <= 1'b0;
            snap_dp  <= '0;
            for (int i = 0; i < DIGITS; i++) snap_seg[i] <= SEG_OFF;
        end else begin
            state    <= state_n;
            slot_cnt <= slot_n;
            idx      <= idx_n;
            seg_q    <= seg_n;
            dp_q     <= dp_n;
            an_q     <= an_n;
            tick_q   <= tick_n;
            if (capture) begin
                snap_dp <= dpm_sel;
                for (int i = 0; i < DIGITS; i++) snap_seg[i] <= disp_sel[i];
            end
        end
    end

`ifdef SEG_DISPLAY_SCANNER_BLINK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snap_blink  <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            if (capture) snap_blink <= bus.blink_mask;
            if (tick_n) begin
                if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end
`endif

    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.an         = an_q;
    assign bus.digit_idx  = idx;
    assign bus.frame_tick = tick_q;
endmodule
